rr_spill_arbiter: RTL
=====================

// Module: rr_spill_arbiter
// PURPOSE
//  Shares one registered stream output between NumInp valid/ready requesters.
//  Picks one requester per cycle by round-robin and pushes its beat into an
//  internal two-entry spill buffer that drives the output.
//  No combinational path exists from any output-side input to any input-side
//  output, or from input-side data to the output.
//  Sits in front of shared interconnect ports and shared clock-domain register slices.
// PARAMETERS
//  NumInp     4   number of requesters; >=2
//  DataWidth  32  payload width in bits; >=1
//  IdxWidth   $clog2(NumInp)  derived, not overridable; width of the source index
// PORTS
//  clk_i        in   1               clock, all logic on rising edge
//  rst_i        in   1               synchronous reset, active-high
//  inp_valid_i  in   NumInp          per-requester valid
//  inp_ready_o  out  NumInp          per-requester ready; one-hot or zero
//  inp_data_i   in   NumInp*DataWidth  requester i payload at [i*DataWidth +: DataWidth]
//  oup_valid_o  out  1               output beat valid
//  oup_ready_i  in   1               downstream accepts
//  oup_data_o   out  DataWidth       output payload
//  oup_idx_o    out  IdxWidth        index of the requester that sourced the beat
// BEHAVIOUR
//  State
//   - Two-entry FIFO: mem[2] of {data, idx}.
//   - 2-bit wr_ptr and rd_ptr; occupancy = wr_ptr - rd_ptr, range 0..2.
//   - rr_ptr (IdxWidth bits) gives the highest-priority requester.
//  Reset (rst_i=1 at a clock edge)
//   - wr_ptr, rd_ptr and rr_ptr go to 0; mem goes to '0.
//   - Buffered beats are dropped, including on reset mid-operation.
//   - While rst_i=1, inp_ready_o is forced to '0 combinationally.
//   - After reset: oup_valid_o=0, oup_data_o='0, oup_idx_o='0.
//  Arbitration (combinational, each cycle)
//   - Eligible only when occupancy<2.
//   - Grant g = first i with inp_valid_i[i]=1, scanning rr_ptr, rr_ptr+1, ... and wrapping NumInp-1 -> 0.
//   - inp_ready_o[g]=1; all other bits are 0.
//   - If nothing is valid or occupancy==2, inp_ready_o='0.
//   - inp_ready_o may depend on inp_valid_i. It never depends on oup_ready_i.
//   - Full plus a pop in the same cycle: no push that cycle. This is deliberate; it cuts the ready path.
//  Push (inp_valid_i[g] && inp_ready_o[g])
//   - mem[wr_ptr[0]] <= {inp_data_i[g], g}; wr_ptr <= wr_ptr+1 (2-bit wrap).
//   - rr_ptr <= (g==NumInp-1) ? 0 : g+1.
//   - rr_ptr holds when there is no push.
//  Output
//   - oup_valid_o = (occupancy != 0).
//   - oup_data_o and oup_idx_o = mem[rd_ptr[0]].
//   - Pop on oup_valid_o && oup_ready_i: rd_ptr <= rd_ptr+1.
//   - Push and pop in the same cycle are allowed when occupancy==1.
//  Timing
//   - Latency is 1 cycle from input handshake to oup_valid_o.
//   - Sustained throughput is 1 beat/cycle when oup_ready_i is held at 1.
//   - While oup_valid_o && !oup_ready_i, oup_valid_o, oup_data_o and oup_idx_o hold stable.
//   - Output order equals grant order.
//  Requester obligation
//   - A requester holds valid and data until its handshake. This is asserted in simulation.
//   - Requester obligations do not affect fairness: a starved-then-granted input is served within NumInp grants.
// TESTING (NumInp=4, DataWidth=8)
//  1. rst_i=1 for 3 cycles with inp_valid_i=4'b1111
//     -> inp_ready_o=0 and oup_valid_o=0 throughout.
//     -> 1st cycle after release: inp_ready_o=4'b0001.
//  2. All valid, data_i=0x10+i, oup_ready_i=1
//     -> oup_idx_o sequence 0,1,2,3,0 on consecutive cycles; data 0x10..0x13,0x10; no bubbles.
//  3. Only input 2 valid, data 0xA1,0xA2,0xA3, oup_ready_i=0
//     -> 0xA1 and 0xA2 accepted, then inp_ready_o=0.
//     -> oup_data_o stays 0xA1.
//     -> after oup_ready_i=1: outputs 0xA1,0xA2,0xA3 in order.
//  4. Occupancy 2, oup_ready_i=1, input 0 valid
//     -> no push in that cycle, push on the next cycle.
//     -> occupancy trace 2,1,1.
//  5. Input 3 granted, then only input 1 valid
//     -> rr_ptr wraps to 0 and input 1 is granted next.
//     -> oup_idx_o = 3 then 1.
//  6. Occupancy 2, rst_i pulsed for 1 cycle
//     -> next cycle oup_valid_o=0 and rr_ptr=0.
//     -> stale beats never appear on the output.

Source files
------------

// File: rtl/rr_spill_arbiter.sv
// Round-robin arbiter that pushes one requester beat per cycle into a two-entry
// spill FIFO; the FIFO registers drive the shared output stream.

module rr_spill_arbiter #(
    parameter int NumInp    = 4,
    parameter int DataWidth = 32,
    localparam int IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumInp-1:0]             inp_valid_i,
    output logic [NumInp-1:0]             inp_ready_o,
    input  logic [NumInp*DataWidth-1:0]   inp_data_i,
    output logic                          oup_valid_o,
    input  logic                          oup_ready_i,
    output logic [DataWidth-1:0]          oup_data_o,
    output logic [IdxWidth-1:0]           oup_idx_o
);

    localparam int unsigned NumU = NumInp;

    logic [1:0]           wr_ptr_r;
    logic [1:0]           rd_ptr_r;
    logic [IdxWidth-1:0]  rr_ptr_r;
    logic [DataWidth-1:0] mem_data_r [2];
    logic [IdxWidth-1:0]  mem_idx_r  [2];

    logic [1:0]           occupancy_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 grant_found_s;
    logic [IdxWidth-1:0]  grant_idx_s;
    logic [DataWidth-1:0] grant_data_s;
    logic [IdxWidth-1:0]  rr_next_s;
    logic [NumInp-1:0]    ready_s;
    logic                 push_s;
    logic                 pop_s;

    function automatic logic [IdxWidth-1:0] wrap_add(
        input logic [IdxWidth-1:0] base,
        input int unsigned         off
    );
        int unsigned sum;
        int unsigned wrapped;
        sum = 32'(base) + off;
        if (sum >= NumU) begin
            wrapped = sum - NumU;
        end else begin
            wrapped = sum;
        end
        return wrapped[IdxWidth-1:0];
    endfunction

    assign occupancy_s = wr_ptr_r - rd_ptr_r;
    assign full_s      = (occupancy_s == 2'd2);
    assign empty_s     = (occupancy_s == 2'd0);

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int unsigned k = 0; k < NumU; k++) begin
            if (!grant_found_s && inp_valid_i[wrap_add(rr_ptr_r, k)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = wrap_add(rr_ptr_r, k);
            end else begin
                grant_found_s = grant_found_s;
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // Full blocks the push even when a pop is pending, so ready never sees oup_ready_i.
    assign push_s       = grant_found_s && !full_s && !rst_i;
    assign pop_s        = !empty_s && oup_ready_i;
    assign grant_data_s = inp_data_i[32'(grant_idx_s) * 32'(DataWidth) +: DataWidth];

    // One-hot ready for the granted requester.
    always_comb begin
        ready_s = '0;
        if (push_s) begin
            ready_s[grant_idx_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    // Priority moves just past the requester that was served.
    always_comb begin
        if (32'(grant_idx_s) == NumU - 32'd1) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_idx_s + IdxWidth'(1);
        end
    end

    // FIFO storage, pointers and round-robin state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r      <= 2'd0;
            rd_ptr_r      <= 2'd0;
            rr_ptr_r      <= '0;
            mem_data_r[0] <= '0;
            mem_data_r[1] <= '0;
            mem_idx_r[0]  <= '0;
            mem_idx_r[1]  <= '0;
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r[0]] <= grant_data_s;
                mem_idx_r[wr_ptr_r[0]]  <= grant_idx_s;
                wr_ptr_r                <= wr_ptr_r + 2'd1;
                rr_ptr_r                <= rr_next_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
        end
    end

    assign inp_ready_o = ready_s;
    assign oup_valid_o = !empty_s;
    assign oup_data_o  = mem_data_r[rd_ptr_r[0]];
    assign oup_idx_o   = mem_idx_r[rd_ptr_r[0]];

    rr_spill_arbiter_chk #(
        .NumInp    (NumInp),
        .DataWidth (DataWidth),
        .IdxWidth  (IdxWidth)
    ) u_chk (
        .clk       (clk_i),
        .rst       (rst_i),
        .inp_valid (inp_valid_i),
        .inp_ready (ready_s),
        .inp_data  (inp_data_i),
        .oup_valid (!empty_s),
        .oup_ready (oup_ready_i),
        .oup_data  (mem_data_r[rd_ptr_r[0]]),
        .oup_idx   (mem_idx_r[rd_ptr_r[0]]),
        .occupancy (occupancy_s)
    );

endmodule

// Protocol and structural properties of rr_spill_arbiter, including the
// requester obligation to hold valid and data until accepted.
module rr_spill_arbiter_chk #(
    parameter int NumInp    = 4,
    parameter int DataWidth = 32,
    parameter int IdxWidth  = 2
) (
    input logic                        clk,
    input logic                        rst,
    input logic [NumInp-1:0]           inp_valid,
    input logic [NumInp-1:0]           inp_ready,
    input logic [NumInp*DataWidth-1:0] inp_data,
    input logic                        oup_valid,
    input logic                        oup_ready,
    input logic [DataWidth-1:0]        oup_data,
    input logic [IdxWidth-1:0]         oup_idx,
    input logic [1:0]                  occupancy
);

    a_ready_onehot: assert property (@(posedge clk) $onehot0(inp_ready));

    a_ready_needs_valid: assert property (@(posedge clk) (inp_ready & ~inp_valid) == '0);

    a_ready_low_in_reset: assert property (@(posedge clk) rst |-> (inp_ready == '0));

    a_occupancy_range: assert property (@(posedge clk) occupancy <= 2'd2);

    // A stalled output beat must not move or change.
    a_oup_hold: assert property (@(posedge clk) disable iff (rst)
        (oup_valid && !oup_ready) |=> (oup_valid && $stable(oup_data) && $stable(oup_idx)));

    for (genvar i = 0; i < NumInp; i++) begin : g_req
        a_req_hold: assert property (@(posedge clk) disable iff (rst)
            (inp_valid[i] && !inp_ready[i]) |=>
            (inp_valid[i] && $stable(inp_data[i*DataWidth +: DataWidth])));
    end

endmodule
